rgb_fade_pwm: RTL

Downstream stage of the colour-sequencing FSM. Takes the FSM's per-channel on/off levels (`red`, `green`, `blue`, active-high) and drives the active-low RGB LED pins. Each channel ramps its duty cycle linearly toward the commanded level, so colour changes cross-fade instead of snapping. It replaces the plain inverters at top level and owns the `RGB_R/G/B` pins.

---
 rtl/rgb_pkg.sv | 20 ++
 rtl/rgb_fade_pwm_channel.sv | 96 +++++++++
 rtl/rgb_fade_pwm.sv | 68 ++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared types and channel indices for the RGB cross-fade PWM stage.
package rgb_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fade_state_t;

    localparam int unsigned R      = 0;
    localparam int unsigned G      = 1;
    localparam int unsigned B      = 2;
    localparam int unsigned NUM_CH = 3;

    function automatic logic is_fading(input fade_state_t st);
        return (st == ST_RISE) || (st == ST_FALL);
    endfunction

endpackage

// File: rtl/rgb_fade_pwm_channel.sv
// One colour channel: fade FSM, duty register and registered active-low pin.
module fade_channel
    import rgb_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                target_i,
    input  logic                tick_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                pin_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1'b1);

    fade_state_t         state_q, state_d;
    logic [PWM_BITS-1:0] duty_q,  duty_d;
    logic                pin_q;
    logic                lit_s;

    // State, duty and pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            duty_q  <= DUTY_ZERO;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            pin_q   <= ~lit_s;
        end
    end

    // Next state; a reversal edge never moves duty, and the saturating
    // compares keep a reversal at duty 0 from underflowing.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_OFF: begin
                duty_d = DUTY_ZERO;
                if (target_i) state_d = ST_RISE;
                else          state_d = ST_OFF;
            end
            ST_RISE: begin
                if (!target_i) begin
                    state_d = ST_FALL;
                end else if (tick_i) begin
                    if (duty_q >= DUTY_MAX - DUTY_ONE) begin
                        duty_d  = DUTY_MAX;
                        state_d = ST_ON;
                    end else begin
                        duty_d  = duty_q + DUTY_ONE;
                    end
                end else begin
                    state_d = ST_RISE;
                end
            end
            ST_ON: begin
                duty_d = DUTY_MAX;
                if (!target_i) state_d = ST_FALL;
                else           state_d = ST_ON;
            end
            ST_FALL: begin
                if (target_i) begin
                    state_d = ST_RISE;
                end else if (tick_i) begin
                    if (duty_q <= DUTY_ONE) begin
                        duty_d  = DUTY_ZERO;
                        state_d = ST_OFF;
                    end else begin
                        duty_d  = duty_q - DUTY_ONE;
                    end
                end else begin
                    state_d = ST_FALL;
                end
            end
            default: begin
                state_d = ST_OFF;
                duty_d  = DUTY_ZERO;
            end
        endcase
    end

    // Outputs: full duty is forced lit so there is no one-count dark gap
    always_comb begin
        lit_s  = (duty_q == DUTY_MAX) || (pwm_cnt_i < duty_q);
        busy_o = is_fading(state_q);
        pin_o  = pin_q;
    end

endmodule

// File: rtl/rgb_fade_pwm.sv
// Three-channel cross-fading PWM driver for the active-low RGB LED pins.
module rgb_fade_pwm
    import rgb_pkg::*;
#(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned STEP_INTERVAL = 46875
) (
    input  logic clk,
    input  logic rst_n,
    input  logic red,
    input  logic green,
    input  logic blue,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B,
    output logic busy
);

    localparam int unsigned STEP_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_INTERVAL - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]   step_q,    step_d;
    logic                tick_s;
    logic [NUM_CH-1:0]   tgt_s, pin_s, ch_busy_s;

    // Free-running PWM counter and duty-step timebase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= {PWM_BITS{1'b0}};
            step_q    <= {STEP_W{1'b0}};
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            step_q    <= step_d;
        end
    end

    // Counter next-state and tick decode
    always_comb begin
        tick_s    = (step_q == STEP_LAST);
        step_d    = tick_s ? {STEP_W{1'b0}} : step_q + STEP_W'(1'b1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1'b1);
    end

    assign tgt_s[R] = red;
    assign tgt_s[G] = green;
    assign tgt_s[B] = blue;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .target_i  (tgt_s[i]),
            .tick_i    (tick_s),
            .pwm_cnt_i (pwm_cnt_q),
            .pin_o     (pin_s[i]),
            .busy_o    (ch_busy_s[i])
        );
    end

    assign RGB_R = pin_s[R];
    assign RGB_G = pin_s[G];
    assign RGB_B = pin_s[B];
    assign busy  = |ch_busy_s;

endmodule
